vram_wr_sched: RTL

//  Schedules HPS->PPU VRAM writes so VRAM only changes during vertical blank.
//  - Sits between the fpgame_soc h2f VRAM interface and the ppu VRAM write port.
//  - Queues CPU writes in a FIFO and drains them one per cycle between vblank_start and vblank_end.
//  - Drives cpu_wr_busy back-pressure and a cpu_vram_wr_irq completion pulse.

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_wr_sched_if.sv | 14 +
 rtl/vram_wr_fifo.sv | 54 +++++
 rtl/vram_wr_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the HPS->PPU VRAM write scheduler: write record and scheduler state.
`timescale 1ns/1ps
package vram_pkg;
    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 64;
    localparam int VRAM_BE_W   = VRAM_DATA_W / 8;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
        logic [VRAM_BE_W-1:0]   byteena;
    } vram_wr_t;

    typedef enum logic {SCHED_WAIT, SCHED_VBLANK} sched_state_t;
endpackage

// File: rtl/vram_wr_sched_if.sv
// VRAM write bus (address, strobe, data, byte enables); master drives, slave receives.
`timescale 1ns/1ps
interface vram_wr_sched_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   addr;
    logic                wren;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] byteena;

    modport master (output addr, wren, data, byteena);
    modport slave  (input  addr, wren, data, byteena);
endinterface

// File: rtl/vram_wr_fifo.sv
// Single-clock FIFO of VRAM write records; read data is registered and valid the cycle after pop.
`timescale 1ns/1ps
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter  int FIFO_DEPTH = 64,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  vram_wr_t       wr_data,
    input  logic           pop,
    output vram_wr_t       rd_data,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);
    vram_wr_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/vram_wr_sched.sv
// Queues CPU VRAM writes and drains them to the PPU only during vertical blank.
// Optional drain statistics (drain_cnt, drain_max) are enabled by `define VRAM_WR_SCHED_STATS_EN.
`timescale 1ns/1ps
module vram_wr_sched
    import vram_pkg::*;
#(
    parameter  int FIFO_DEPTH = 64,
    parameter  int ADDR_W     = VRAM_ADDR_W,
    parameter  int DATA_W     = VRAM_DATA_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int BE_W       = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vram_wr_sched_if.slave         h2f,
    vram_wr_sched_if.master        vram,
    input  logic                   vblank_start,
    input  logic                   vblank_end,
    output logic                   cpu_wr_busy,
    output logic                   cpu_vram_wr_irq,
    output logic                   ovf_sticky,
    input  logic                   ovf_clr
`ifdef VRAM_WR_SCHED_STATS_EN
    ,
    output logic [15:0]            drain_cnt,
    output logic [CNT_W-1:0]       drain_max
`endif
);
    vram_wr_t     wr_in;
    vram_wr_t     rd_p1;
    logic         vld_p1;
    logic         full;
    logic         empty;
    logic         push_ok;
    logic         pop;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    sched_state_t state;
    sched_state_t state_next;

    assign wr_in.addr    = VRAM_ADDR_W'(h2f.addr);
    assign wr_in.data    = VRAM_DATA_W'(h2f.data);
    assign wr_in.byteena = VRAM_BE_W'(h2f.byteena);
    assign push_ok       = h2f.wren && !full;

    vram_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (h2f.wren),
        .wr_data (wr_in),
        .pop     (pop),
        .rd_data (rd_p1),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // vblank_end suppresses the pop in its own cycle, and also wins over a simultaneous vblank_start.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            SCHED_WAIT: begin
                if (vblank_start && !vblank_end) state_next = SCHED_VBLANK;
            end
            SCHED_VBLANK: begin
                if (vblank_end) state_next = SCHED_WAIT;
                else            pop        = !empty;
            end
            default: state_next = SCHED_WAIT;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push_ok && !pop)      count_next = count + 1'b1;
        else if (pop && !push_ok) count_next = count - 1'b1;
    end

    // Busy looks at the post-edge occupancy so it is already high when the CPU samples it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= SCHED_WAIT;
            vld_p1          <= 1'b0;
            cpu_wr_busy     <= 1'b0;
            cpu_vram_wr_irq <= 1'b0;
            ovf_sticky      <= 1'b0;
        end else begin
            state           <= state_next;
            vld_p1          <= pop;
            cpu_wr_busy     <= (count_next >= CNT_W'(FIFO_DEPTH - 2));
            cpu_vram_wr_irq <= pop && (count_next == '0);
            ovf_sticky      <= (h2f.wren && full) || (ovf_sticky && !ovf_clr);
        end
    end

    // ---- output stage p1: FIFO read register drives the PPU port directly ----
    assign vram.wren    = vld_p1;
    assign vram.addr    = ADDR_W'(rd_p1.addr);
    assign vram.data    = DATA_W'(rd_p1.data);
    assign vram.byteena = BE_W'(rd_p1.byteena);

`ifdef VRAM_WR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= '0;
            drain_max <= '0;
        end else begin
            if (vblank_start)                          drain_cnt <= '0;
            else if (vld_p1 && drain_cnt != 16'hFFFF)  drain_cnt <= drain_cnt + 1'b1;
            if (count > drain_max) drain_max <= count;
        end
    end
`endif
endmodule
